// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the single shared memory port: round-robin between fetch and
// data requests, holds the access for a fixed latency, captures read data, pulses done.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              Reset_signal,
  input  logic              If_req,
  input  logic [ADDR_W-1:0] If_addr,
  input  logic              D_req,
  input  logic              D_wr,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic              Mem_wr,
  output logic [DATA_W-1:0] Mem_wdata,
  input  logic [DATA_W-1:0] Mem_rdata,
  output logic [DATA_W-1:0] Rdata,
  output logic              If_done,
  output logic              D_done,
  output logic              Busy,
  output logic [1:0]        StateOut
);

  localparam int CNT_W = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;          // 1 = data, 0 = fetch
  logic                last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic pick_data;
  logic cnt_hit;

  // On a tie, serve whichever requester did not win last time.
  assign pick_data = D_req && (!If_req || !last_grant_q);
  assign cnt_hit   = (cnt_q == CNT_W'(RD_LAT));

  always_ff @(posedge Clk) begin
    if (Reset_signal) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (If_req || D_req) begin
          grant_d      = pick_data;
          last_grant_d = pick_data;
          cnt_d        = '0;
          state_d      = ACCESS;
          if (pick_data) begin
            addr_d  = D_addr;
            wr_d    = D_wr;
            wdata_d = D_wdata;
          end else begin
            addr_d  = If_addr;
            wr_d    = 1'b0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_hit) begin
          if (!wr_q) rdata_d = Mem_rdata;
          state_d = COMPLETE;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    Mem_wr   = (state_q == ACCESS) && wr_q;
    If_done  = (state_q == COMPLETE) && !grant_q;
    D_done   = (state_q == COMPLETE) && grant_q;
    Busy     = (state_q == ACCESS) || (state_q == COMPLETE);
    StateOut = state_q;
  end

  assign Mem_addr  = addr_q;
  assign Mem_wdata = wdata_q;
  assign Rdata     = rdata_q;

endmodule
